// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: 1-to-4 stream demultiplexer with a one-entry output
// buffer per destination. A word is accepted when in_valid & in_ready and
// appears on y[sel] one cycle later. Each destination drains independently
// through its own y_valid/y_ready handshake.
// Optional macro DEMUX_STATS_EN adds the 8-bit accepted-word counter acc_cnt.
module demux_1_4_stream #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    input  logic [1:0]   sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [3:0]   y_valid,
    input  logic [3:0]   y_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0]   acc_cnt
`endif
);

    logic [W-1:0] ybuf [4];
    logic [3:0]   v;
    logic         accept;
    logic [3:0]   load;

    // A destination can take a word if it is empty or is being drained this cycle
    always_comb begin
        in_ready = ~v[sel] | y_ready[sel];
        accept   = in_valid & in_ready;
        load     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            load[i] = accept && (sel == i[1:0]);
        end
    end

    // Per-destination buffer: load on accept, clear full flag on delivery
    // unless the same edge refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                ybuf[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (load[i]) begin
                    ybuf[i] <= d;
                end
                v[i] <= load[i] | (v[i] & ~y_ready[i]);
            end
        end
    end

`ifdef DEMUX_STATS_EN
    // Count accepted words, wrapping at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + 8'd1;
        end
    end
`endif

    assign y0      = ybuf[0];
    assign y1      = ybuf[1];
    assign y2      = ybuf[2];
    assign y3      = ybuf[3];
    assign y_valid = v;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed testbench for demux_1_4_stream: reset, routing, backpressure,
// full throughput, idle and (with DEMUX_STATS_EN) the accept counter.
module tb_demux_1_4_stream;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic [1:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] y0, y1, y2, y3;
    logic [3:0] y_valid;
    logic [3:0] y_ready;
`ifdef DEMUX_STATS_EN
    logic [7:0] acc_cnt;
`endif

    int unsigned tests;
    int unsigned failed;

    demux_1_4_stream #(.W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
`ifdef DEMUX_STATS_EN
        ,
        .acc_cnt  (acc_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        rst_n    = 1'b0;
        d        = '0;
        sel      = '0;
        in_valid = 1'b0;
        y_ready  = '0;

        // Reset state
        #1;
        chk("rst_y_valid", y_valid, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            sel = i[1:0];
            #1;
            chk("rst_in_ready", in_ready, 1'b1);
        end
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_y_valid", y_valid, 4'b0000);

        // Routing: A,B,C,D to sel 0..3 with all consumers ready
        y_ready  = 4'hF;
        in_valid = 1'b1;
        d = 4'hA; sel = 2'd0; tick();
        chk("route0_valid", y_valid, 4'b0001); chk("route0_y0", y0, 4'hA);
        d = 4'hB; sel = 2'd1; tick();
        chk("route1_valid", y_valid, 4'b0010); chk("route1_y1", y1, 4'hB);
        d = 4'hC; sel = 2'd2; tick();
        chk("route2_valid", y_valid, 4'b0100); chk("route2_y2", y2, 4'hC);
        d = 4'hD; sel = 2'd3; tick();
        chk("route3_valid", y_valid, 4'b1000); chk("route3_y3", y3, 4'hD);
        in_valid = 1'b0; tick();
        chk("route_drain", y_valid, 4'b0000);

        // Backpressure on destination 2
        y_ready  = 4'b1011;
        in_valid = 1'b1;
        d = 4'h5; sel = 2'd2; #1;
        chk("bp_ready_empty", in_ready, 1'b1);
        tick();
        chk("bp_valid5", y_valid, 4'b0100); chk("bp_y2_5", y2, 4'h5);
        d = 4'h6; sel = 2'd2; #1;
        chk("bp_stall_ready", in_ready, 1'b0);
        tick();
        chk("bp_held_valid", y_valid, 4'b0100); chk("bp_held_y2", y2, 4'h5);
        sel = 2'd1; #1;
        chk("bp_other_ready", in_ready, 1'b1);
        d = 4'h7; sel = 2'd0; #1;
        chk("bp_sel0_ready", in_ready, 1'b1);
        tick();
        chk("bp_y0_valid", y_valid, 4'b0101); chk("bp_y0_7", y0, 4'h7);
        chk("bp_y2_still5", y2, 4'h5);
        y_ready = 4'hF;
        d = 4'h6; sel = 2'd2; #1;
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_deliver5", y2, 4'h5);
        tick();
        chk("bp_valid6", y_valid, 4'b0100); chk("bp_y2_6", y2, 4'h6);
        in_valid = 1'b0; tick();
        chk("bp_drain", y_valid, 4'b0000);

        // Full throughput on destination 1
        in_valid = 1'b1;
        sel      = 2'd1;
        for (int k = 1; k <= 6; k++) begin
            d = k[3:0]; #1;
            chk("thr_ready", in_ready, 1'b1);
            tick();
            chk("thr_valid", y_valid, 4'b0010);
            chk("thr_y1", y1, k);
        end
        in_valid = 1'b0; tick();
        chk("thr_drain", y_valid, 4'b0000);

        // Idle: d/sel toggle with in_valid low
        y_ready = 4'h0;
        for (int k = 0; k < 10; k++) begin
            sel = 2'($urandom_range(0, 3));
            d   = 4'($urandom_range(0, 15));
            tick();
            chk("idle_valid", y_valid, 4'b0000);
        end
        chk("idle_y0", y0, 4'h7);
        chk("idle_y1", y1, 4'h6);
        chk("idle_y2", y2, 4'h6);
        chk("idle_y3", y3, 4'hD);

        // Asynchronous reset with v = 1010
        in_valid = 1'b1;
        d = 4'h9; sel = 2'd1; tick();
        d = 4'hE; sel = 2'd3; tick();
        in_valid = 1'b0;
        chk("mid_valid_1010", y_valid, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", y_valid, 4'b0000);
        chk("arst_y0", y0, 4'h0); chk("arst_y1", y1, 4'h0);
        chk("arst_y2", y2, 4'h0); chk("arst_y3", y3, 4'h0);
        sel = 2'd3; #0;
        #1;
        chk("arst_ready3", in_ready, 1'b1);
        sel = 2'd1;
        #1;
        chk("arst_ready1", in_ready, 1'b1);
        y_ready = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_no_deliver", y_valid, 4'b0000);
        in_valid = 1'b1; d = 4'h3; sel = 2'd2; tick();
        in_valid = 1'b0;
        chk("post_arst_valid", y_valid, 4'b0100); chk("post_arst_y2", y2, 4'h3);
        tick();

`ifdef DEMUX_STATS_EN
        // Accept counter: 257 accepts from reset wraps to 1
        rst_n = 1'b0; #1;
        chk("cnt_rst", acc_cnt, 8'd0);
        tick();
        rst_n    = 1'b1;
        y_ready  = 4'hF;
        in_valid = 1'b1;
        sel      = 2'd0;
        for (int k = 0; k < 255; k++) begin
            d = k[3:0];
            tick();
        end
        chk("cnt_255", acc_cnt, 8'd255);
        tick();
        chk("cnt_wrap0", acc_cnt, 8'd0);
        tick();
        chk("cnt_257", acc_cnt, 8'd1);
        in_valid = 1'b0;
        tick();
        chk("cnt_hold", acc_cnt, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter: W, default 4, data width of the input word and of each output word.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 d  input  W  input data word.
REQ-005 sel  input  2  destination select; 0..3 routes to y0..y3.
REQ-006 in_valid  input  1  d/sel are valid this cycle.
REQ-007 in_ready  output  1  block accepts d this cycle.
REQ-008 y0, y1, y2, y3  output  W each  registered output data per destination.
REQ-009 y_valid  output  4  bit i: yi holds an undelivered word.
REQ-010 y_ready  input  4  bit i: consumer i takes yi this cycle.
REQ-011 acc_cnt  output  8  accepted-word count; present only with DEMUX_STATS_EN.

Function
REQ-012 Each destination i SHALL own a one-entry buffer: data register yi and full flag v[i]; y_valid[i] = v[i].
REQ-013 The block SHALL assert in_ready = ~v[sel] | y_ready[sel], combinational from sel, v and y_ready; it SHALL NOT depend on in_valid.
REQ-014 The block SHALL accept a word when in_valid & in_ready at a rising edge.
REQ-015 Accept SHALL load d into y[sel] and set v[sel]; the word SHALL appear at y[sel] with y_valid[sel]=1 one cycle after accept (latency 1).
REQ-016 Destination i SHALL deliver when v[i] & y_ready[i] at a rising edge; v[i] SHALL clear unless the same edge also accepts a word for i.
REQ-017 Simultaneous deliver and accept on the same i SHALL replace yi with the new word and keep v[i]=1 (full throughput, one word/cycle per destination).
REQ-018 A destination SHALL hold yi and v[i] stable while v[i]=1 and y_ready[i]=0.
REQ-019 Destinations not addressed by sel SHALL be unaffected by the accept; their deliveries SHALL proceed independently in the same cycle.
REQ-020 With in_valid=0, d and sel SHALL have no effect on state.
REQ-021 yi SHALL hold its last value after delivery (v[i]=0); consumers SHALL qualify yi with y_valid[i].
REQ-022 A stalled destination SHALL block only words addressed to it (in_ready=0 when sel addresses it); it SHALL NOT block other sel values.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately clear v[3:0], y0..y3 to 0 and acc_cnt to 0, regardless of clk.
REQ-024 After reset, y_valid=4'b0000 and in_ready=1 for every sel.
REQ-025 Reset asserted mid-operation SHALL discard all buffered words; none SHALL be delivered after release.
REQ-026 Deassertion of rst_n SHALL take effect on the first following rising edge of clk.

Configuration
REQ-027 Macro DEMUX_STATS_EN: when defined, port acc_cnt SHALL exist and increment by 1 on every accept, wrapping 255 -> 0; when undefined, port and counter SHALL be absent and routing behaviour SHALL be identical.

Verification
REQ-028 Reset: rst_n=0 mid-run with v=4'b1010 -> y_valid=0, y0..y3=0, in_ready=1 without a clk edge.
REQ-029 Routing: y_ready=4'hF, send d=a,b,c,d with sel=0,1,2,3 on consecutive cycles -> y0=a, y1=b, y2=c, y3=d each valid exactly one cycle, one cycle after its accept.
REQ-030 Backpressure: y_ready[2]=0, send d=5 sel=2 then d=6 sel=2 -> y2=5 held, in_ready=0 for sel=2; in_ready=1 for sel=0 and d=7 sel=0 delivers on y0; raise y_ready[2] -> 5 delivered, then 6.
REQ-031 Full throughput: v[1]=1, y_ready[1]=1, in_valid=1, sel=1 every cycle with d=1,2,3,... -> y1 updates every cycle, no bubble, in_ready stays 1.
REQ-032 Idle: in_valid=0 while sel and d toggle randomly -> y_valid stays 0, y0..y3 unchanged.
REQ-033 Stats (DEMUX_STATS_EN): 257 accepts from reset -> acc_cnt=1; build without macro passes REQ-028..REQ-032 unchanged.
